// File: rtl/shift_ctrl_pkg.sv
// Shared types and width helpers for the serial shift controller.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-load, serial-out, left-shift register; MSB is the serial bit.
module shift_reg_piso #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority; shifting fills zeros so a finished frame leaves 0.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift_en) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_shift_ctrl.sv
// Word-to-serial sequencer: accepts a word, shifts it out MSB-first at
// DIV clocks per bit, strobing bit_tick and pulsing done at frame end.
module serial_shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             bit_tick,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DIV_W = cnt_width(DIV);
    localparam int unsigned BIT_W = cnt_width(WIDTH);

    shift_state_t     state_q;
    shift_state_t     state_d;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [BIT_W-1:0] bit_cnt_d;
    logic             load;
    logic             shift_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state and outputs, all decoded from registered state; in_ready
    // is additionally masked by reset so nothing is accepted during reset.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        in_ready  = 1'b0;
        bit_tick  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    load      = 1'b1;
                    state_d   = SHIFT;
                    bit_cnt_d = BIT_W'(WIDTH - 1);
                    div_cnt_d = DIV_W'(DIV - 1);
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (div_cnt_q == '0) begin
                    bit_tick  = 1'b1;
                    shift_en  = 1'b1;
                    div_cnt_d = DIV_W'(DIV - 1);
                    if (bit_cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DIV_W'(1);
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    shift_reg_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (in_data),
        .shift_en  (shift_en),
        .msb       (ser_out)
    );

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Directed bench for serial_shift_ctrl with three parameterisations:
// a = (8,4), b = (8,1), c = (5,3).
module tb_serial_shift_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       reset_a = 1'b1, in_valid_a = 1'b0;
    logic [7:0] in_data_a = '0;
    logic       in_ready_a, ser_out_a, bit_tick_a, busy_a, done_a;

    logic       reset_b = 1'b1, in_valid_b = 1'b0;
    logic [7:0] in_data_b = '0;
    logic       in_ready_b, ser_out_b, bit_tick_b, busy_b, done_b;

    logic       reset_c = 1'b1, in_valid_c = 1'b0;
    logic [4:0] in_data_c = '0;
    logic       in_ready_c, ser_out_c, bit_tick_c, busy_c, done_c;

    serial_shift_ctrl #(.WIDTH(8), .DIV(4)) dut_a (
        .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .ser_out(ser_out_a), .bit_tick(bit_tick_a),
        .busy(busy_a), .done(done_a)
    );

    serial_shift_ctrl #(.WIDTH(8), .DIV(1)) dut_b (
        .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .ser_out(ser_out_b), .bit_tick(bit_tick_b),
        .busy(busy_b), .done(done_b)
    );

    serial_shift_ctrl #(.WIDTH(5), .DIV(3)) dut_c (
        .clk(clk), .reset(reset_c), .in_valid(in_valid_c), .in_data(in_data_c),
        .in_ready(in_ready_c), .ser_out(ser_out_c), .bit_tick(bit_tick_c),
        .busy(busy_c), .done(done_c)
    );

    // Observed outputs packed as {in_ready, ser_out, bit_tick, busy, done}.
    logic [4:0] obs_a, obs_b, obs_c;
    assign obs_a = {in_ready_a, ser_out_a, bit_tick_a, busy_a, done_a};
    assign obs_b = {in_ready_b, ser_out_b, bit_tick_b, busy_b, done_b};
    assign obs_c = {in_ready_c, ser_out_c, bit_tick_c, busy_c, done_c};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] get_obs(input int inst);
        case (inst)
            0:       return obs_a;
            1:       return obs_b;
            default: return obs_c;
        endcase
    endfunction

    function automatic int get_w(input int inst);
        return (inst == 2) ? 5 : 8;
    endfunction

    function automatic int get_d(input int inst);
        case (inst)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic set_valid(input int inst, input logic v);
        case (inst)
            0:       in_valid_a = v;
            1:       in_valid_b = v;
            default: in_valid_c = v;
        endcase
    endtask

    task automatic set_data(input int inst, input logic [7:0] d);
        case (inst)
            0:       in_data_a = d;
            1:       in_data_b = d;
            default: in_data_c = 5'(d);
        endcase
    endtask

    // Expected outputs n cycles after the acceptance edge.
    function automatic logic [4:0] exp_vec(input int n, input int w, input int d,
                                           input logic [31:0] word);
        int idx;
        if (n <= w * d) begin
            idx = w - 1 - (n - 1) / d;
            return {1'b0, word[idx], (n % d == 0), 1'b1, 1'b0};
        end else if (n == w * d + 1) begin
            return 5'b00011;
        end
        return 5'b10000;
    endfunction

    // Sends one word and checks every cycle through the return to IDLE.
    task automatic do_frame(input int inst, input logic [7:0] word, input int chg_at,
                            input logic [7:0] chg_val, input logic hold,
                            input logic poke_done, input string tag);
        int w, d;
        logic [4:0] exp, got;
        w = get_w(inst);
        d = get_d(inst);
        set_data(inst, word);
        set_valid(inst, 1'b1);
        checks++;
        got = get_obs(inst);
        if (got[4] !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready before accept: got %b want 1", tag, got[4]);
        end
        step();
        for (int n = 1; n <= w * d + 2; n++) begin
            if (n == 1 && !hold) set_valid(inst, 1'b0);
            if (n == chg_at) set_data(inst, chg_val);
            if (poke_done && n == w * d + 1) begin
                set_data(inst, 8'h55);
                set_valid(inst, 1'b1);
            end
            if (poke_done && n == w * d + 2) set_valid(inst, 1'b0);
            exp = exp_vec(n, w, d, 32'(word));
            got = get_obs(inst);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle T+%0d {rdy,ser,tick,busy,done}: got %b want %b",
                         tag, n, got, exp);
            end
            if (n < w * d + 2) step();
        end
    endtask

    task automatic test_reset();
        step();
        checks += 3;
        if (obs_a !== 5'b00000) begin errors++; $display("FAIL reset_a outputs: got %b want 00000", obs_a); end
        if (obs_b !== 5'b00000) begin errors++; $display("FAIL reset_b outputs: got %b want 00000", obs_b); end
        if (obs_c !== 5'b00000) begin errors++; $display("FAIL reset_c outputs: got %b want 00000", obs_c); end
        step();
        reset_a = 1'b0;
        reset_b = 1'b0;
        reset_c = 1'b0;
        #1;
        checks += 3;
        if (obs_a !== 5'b10000) begin errors++; $display("FAIL release_a outputs: got %b want 10000", obs_a); end
        if (obs_b !== 5'b10000) begin errors++; $display("FAIL release_b outputs: got %b want 10000", obs_b); end
        if (obs_c !== 5'b10000) begin errors++; $display("FAIL release_c outputs: got %b want 10000", obs_c); end
    endtask

    task automatic test_basic_frame();
        do_frame(0, 8'hA5, 0, 8'h00, 1'b0, 1'b0, "a5_frame");
        step();
    endtask

    task automatic test_back_to_back();
        do_frame(1, 8'hFF, 1, 8'h00, 1'b1, 1'b0, "b2b_ff");
        do_frame(1, 8'h00, 0, 8'h00, 1'b1, 1'b0, "b2b_00");
        set_valid(1, 1'b0);
        step();
        checks++;
        if (obs_b !== 5'b10000) begin
            errors++;
            $display("FAIL b2b_idle outputs: got %b want 10000", obs_b);
        end
    endtask

    task automatic test_reset_abort();
        logic [4:0] exp;
        set_data(0, 8'h3C);
        set_valid(0, 1'b1);
        step();
        set_valid(0, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            exp = exp_vec(n, 8, 4, 32'h3C);
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL abort_pre cycle T+%0d: got %b want %b", n, obs_a, exp);
            end
            if (n < 10) step();
        end
        reset_a = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 1'b0) begin errors++; $display("FAIL abort_rdy_in_reset: got %b want 0", in_ready_a); end
        step();
        checks++;
        if (obs_a !== 5'b00000) begin errors++; $display("FAIL abort_cleared: got %b want 00000", obs_a); end
        reset_a = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (obs_a !== 5'b10000) begin
                errors++;
                $display("FAIL abort_idle cycle %0d: got %b want 10000", n, obs_a);
            end
            step();
        end
        do_frame(0, 8'h81, 0, 8'h00, 1'b0, 1'b0, "after_abort_81");
        step();
    endtask

    task automatic test_data_change();
        do_frame(0, 8'h0F, 5, 8'hF0, 1'b0, 1'b0, "data_change");
        step();
    endtask

    task automatic test_no_accept();
        reset_a = 1'b1;
        set_data(0, 8'h55);
        set_valid(0, 1'b1);
        #1;
        checks++;
        if (in_ready_a !== 1'b0) begin errors++; $display("FAIL valid_in_reset in_ready: got %b want 0", in_ready_a); end
        step();
        reset_a = 1'b0;
        set_valid(0, 1'b0);
        #1;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (obs_a !== 5'b10000) begin
                errors++;
                $display("FAIL valid_in_reset idle %0d: got %b want 10000", n, obs_a);
            end
            step();
        end
        do_frame(0, 8'hC3, 0, 8'h00, 1'b0, 1'b1, "valid_in_done");
        step();
        checks++;
        if (obs_a !== 5'b10000) begin errors++; $display("FAIL valid_in_done after: got %b want 10000", obs_a); end
    endtask

    task automatic test_odd_width();
        do_frame(2, 8'h13, 0, 8'h00, 1'b0, 1'b0, "w5_d3_10011");
        step();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_reset_abort();
        test_data_change();
        test_no_accept();
        test_odd_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_shift_ctrl.md
# serial_shift_ctrl

Sequencer for the 4-to-N-bit serial shift register datapath. Accepts a parallel word over a valid/ready handshake, loads it into a parallel-load shift register, and shifts it out MSB-first at a programmable bit rate. Emits a per-bit strobe and an end-of-frame pulse. Sits between a word-producing client and any serial sink that samples on `bit_tick`.

## Interface

Parameters:
- `WIDTH`, 8: word length in bits. Must be ≥ 2.
- `DIV`, 4: clock cycles per serial bit. Must be ≥ 1.

Ports:
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: the client offers `in_data`.
- `in_data`, in, WIDTH: the parallel word to transmit.
- `in_ready`, out, 1: the controller can accept a word.
- `ser_out`, out, 1: the serial data bit, which is the current MSB of the shift register.
- `bit_tick`, out, 1: one-cycle strobe on the last cycle of each bit period.
- `busy`, out, 1: a frame is in progress (SHIFT or DONE).
- `done`, out, 1: one-cycle pulse after the last bit of a frame.

## Operation

States are IDLE, SHIFT and DONE.

Counters:
- `div_cnt` is $clog2(DIV) bits wide, with a minimum of 1 bit.
- `bit_cnt` is $clog2(WIDTH) bits wide.

IDLE:
- `in_ready` = 1.
- A word is accepted when `in_valid && in_ready`.
- On acceptance, the next state is SHIFT.
- On the same edge: shift register ← `in_data`, `bit_cnt` ← WIDTH-1, `div_cnt` ← DIV-1.

SHIFT:
- `ser_out` = shift register [WIDTH-1].
- `div_cnt` decrements each cycle.
- When `div_cnt` == 0:
  - `bit_tick` = 1.
  - The register shifts left, filling a 0 at bit 0.
  - `div_cnt` reloads DIV-1.
  - If `bit_cnt` == 0, the next state is DONE. Otherwise `bit_cnt` decrements.
- `in_valid` is ignored. `in_ready` = 0.

DONE:
- `done` = 1 for exactly one cycle, then the next state is IDLE.
- `in_ready` = 0 in DONE. There is no back-to-back acceptance inside DONE.

Reset values, held while `reset` = 1 and taken on the next edge:
- State IDLE, shift register 0, both counters 0.
- `ser_out` = 0, `bit_tick` = 0, `busy` = 0, `done` = 0.
- `in_ready` = 0 while `reset` is high. It is gated combinationally with `!reset`.

Boundary conditions:
- Reset asserted mid-frame aborts the frame. No `done` pulse is produced, and the remaining bits are discarded.
- `in_valid` asserted together with `reset` is not accepted.
- DIV = 1: `bit_tick` is high every SHIFT cycle.
- `in_data` is sampled only on the acceptance edge. Later changes to it have no effect.

## Timing

- Acceptance on edge T.
- SHIFT occupies cycles T+1 … T+WIDTH·DIV.
- `bit_tick` for bit k (k = 0 is the MSB) occurs at cycle T+(k+1)·DIV.
- DONE (`done` = 1) at cycle T+WIDTH·DIV+1.
- `in_ready` = 1 again at cycle T+WIDTH·DIV+2.
- Frame period with `in_valid` held high is WIDTH·DIV+2 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from `in_valid` or `in_data` to any output.

## Structure

Package `shift_ctrl_pkg` holds:
- `typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t`.
- Localparam helpers for counter widths.

Sub-module `shift_reg_piso`: a parallel-load, serial-out, left-shift register with this interface:
- `clk`, `reset`.
- `load`, `load_data[WIDTH-1:0]`.
- `shift_en`.
- `msb`.

The controller instantiates it once and drives `load` and `shift_en` from the state machine and `div_cnt`.

## Test plan

1. WIDTH=8, DIV=4. Reset for 2 cycles, then send 0xA5.
   - `ser_out` sequence is 1,0,1,0,0,1,0,1, each bit held 4 cycles.
   - 8 `bit_tick` pulses, spaced 4 cycles apart.
   - `done` at T+33, `in_ready` at T+34.
2. DIV=1, `in_valid` held high, words 0xFF then 0x00.
   - `bit_tick` is continuous during SHIFT.
   - Frames are 10 cycles apart.
   - `ser_out` is all ones, then all zeros.
3. Assert `reset` at cycle T+10 of a 0x3C frame.
   - The next cycle shows all outputs 0 and the state is IDLE.
   - No `done` pulse.
   - After reset deasserts, `in_ready` = 1 and a fresh word 0x81 transmits cleanly.
4. Change `in_data` from 0x0F to 0xF0 during SHIFT. The transmitted bits remain 0,0,0,0,1,1,1,1.
5. Assert `in_valid` in the same cycle as `reset`, and again during DONE. Neither word is accepted. `in_ready` is low in both cases.
6. WIDTH=5, DIV=3, word 5'b10011.
   - 5 ticks at T+3, 6, 9, 12, 15.
   - `done` at T+16.
